// File: rtl/cnn_layer_sequencer_pkg.sv
// cnn_ctrl_pkg: shared types and constants for the CNN layer sequencer.
//   seq_state_t         - sequencer FSM state encoding (3 bits)
//   layer_idx_w()       - width of a layer index for a given layer count
//   LAYER_IDX_W         - layer index width for the default 4-layer chain
//   DEF_TIMEOUT_CYCLES  - default per-layer watchdog limit
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERROR  = 3'd5
  } seq_state_t;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;

  // A single-layer chain still needs a 1-bit index port.
  function automatic int unsigned layer_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LAYER_IDX_W = layer_idx_w(4);

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: run control, engine handshake and status bundle.
//   master : host/engine side (drives run_req, abort, layer_mask, layer_done)
//   slave  : sequencer side (drives layer_start, layer_ena, busy, done,
//            error, err_layer, cur_layer, run_cycles)
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RUNCNT_W   = 24
);
  localparam int LW = cnn_ctrl_pkg::layer_idx_w(NUM_LAYERS);

  logic                  run_req;
  logic                  abort;
  logic [NUM_LAYERS-1:0] layer_mask;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [NUM_LAYERS-1:0] layer_ena;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [LW-1:0]         err_layer;
  logic [LW-1:0]         cur_layer;
  logic [RUNCNT_W-1:0]   run_cycles;

  modport master (
    output run_req, abort, layer_mask, layer_done,
    input  layer_start, layer_ena, busy, done, error, err_layer, cur_layer, run_cycles
  );

  modport slave (
    input  run_req, abort, layer_mask, layer_done,
    output layer_start, layer_ena, busy, done, error, err_layer, cur_layer, run_cycles
  );

endinterface

// File: rtl/cnn_layer_sequencer_watchdog.sv
// layer_watchdog: per-layer timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (asserted in the START cycle)
//   en       : count this cycle (asserted in WAIT)
//   expired  : registered, high while the count sits at TIMEOUT_CYCLES-1
module layer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = cnn_ctrl_pkg::DEF_TIMEOUT_CYCLES,
  parameter int unsigned TMR_W          = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt, cnt_n;

  // Hold at the limit so a stalled engine can never wrap the count.
  always_comb begin
    cnt_n = cnt;
    if (clear)                   cnt_n = '0;
    else if (en && cnt != LIMIT) cnt_n = cnt + 1'b1;
  end

  // Comparing the next value makes expired line up with the count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      expired <= (cnt_n == LIMIT);
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs the enabled CNN layer engines in index order
// (start pulse -> wait for done -> next), gates each engine enable, guards
// every layer with a watchdog and reports status and run length.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cnn_layer_sequencer_if.slave (run control, engine handshake, status)
module cnn_layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_W          = 21,
  parameter int RUNCNT_W       = 24
) (
  input logic                  clk,
  input logic                  rst,
  cnn_layer_sequencer_if.slave bus
);
  localparam int LW   = layer_idx_w(NUM_LAYERS);
  // One extra code so idx can reach NUM_LAYERS ("all layers visited").
  localparam int IDXW = $clog2(NUM_LAYERS + 1);

  seq_state_t            state, state_n;
  logic [IDXW-1:0]       idx, idx_n;
  logic [LW-1:0]         idx_t;
  logic [NUM_LAYERS-1:0] mask_q, ena_q, ena_n, start_oh;
  logic                  err_q;
  logic [LW-1:0]         err_layer_q;
  logic [RUNCNT_W-1:0]   runc_q;
  logic                  wd_expired;
  logic                  act_done;

  assign idx_t    = idx[LW-1:0];
  assign act_done = bus.layer_done[idx_t];

  layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == S_START),
    .en     (state == S_WAIT),
    .expired(wd_expired)
  );

  // State register plus run bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      mask_q      <= '0;
      ena_q       <= '0;
      err_q       <= 1'b0;
      err_layer_q <= '0;
      runc_q      <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ena_q <= ena_n;
      if (state == S_IDLE) begin
        if (bus.run_req) begin
          mask_q <= bus.layer_mask;
          err_q  <= 1'b0;
          runc_q <= '0;
        end
      end else if (runc_q != '1) begin
        runc_q <= runc_q + 1'b1;
      end
      // An abort landing on the ERROR cycle abandons the run without flagging it.
      if (state == S_ERROR && !bus.abort) begin
        err_q       <= 1'b1;
        err_layer_q <= idx_t;
      end
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: if (bus.run_req) begin
        state_n = S_SELECT;
        idx_n   = '0;
      end
      S_SELECT: begin
        if (idx == IDXW'(NUM_LAYERS)) state_n = S_FINISH;
        else if (!mask_q[idx_t])      idx_n   = idx + 1'b1;
        else                          state_n = S_START;
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (act_done) begin
          idx_n   = idx + 1'b1;
          state_n = S_SELECT;
        end else if (wd_expired) begin
          state_n = S_ERROR;
        end
      end
      S_FINISH: state_n = S_IDLE;
      S_ERROR:  state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (bus.abort && state != S_IDLE) state_n = S_IDLE;
  end

  // Output decode. ena is registered from the next state, so it covers
  // START..done cycle and falls on the cycle after the accepted done.
  always_comb begin
    start_oh = '0;
    ena_n    = '0;
    if (state == S_START) start_oh[idx_t] = 1'b1;
    if (state_n == S_START || state_n == S_WAIT) ena_n[idx_n[LW-1:0]] = 1'b1;
  end

  assign bus.layer_start = start_oh;
  assign bus.layer_ena   = ena_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_FINISH);
  assign bus.error       = err_q;
  assign bus.err_layer   = err_layer_q;
  assign bus.cur_layer   = idx_t;
  assign bus.run_cycles  = runc_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer. Engine models answer each start
// after a programmed latency (0 = never); a run-level reference model predicts
// start cycles, enable lengths, done/error, run length from the sequencing rules.
module tb_cnn_layer_sequencer;
  localparam int NL = 4, TO = 16, TW = 5, RCW = 24, LW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_sequencer_if #(.NUM_LAYERS(NL), .RUNCNT_W(RCW)) bus ();

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .TMR_W(TW), .RUNCNT_W(RCW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_mis = 0;

  // engine latencies and observations of one run (cycles relative to accept)
  int lat[NL];
  int due[NL];
  int o_nstart[NL], o_start_rc[NL], o_enacnt[NL];
  int o_ndone, o_done_rc, o_multi, o_end_rc;
  // model predictions
  int e_start[NL], e_ena[NL];
  int e_ndone, e_done_rc, e_err, e_errl, e_runc, e_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: record outputs, drive engine done bits, advance past the edge.
  // spur: 0 none, 1 random pulses on idle layers, 2 every idle layer held high.
  task automatic step(input int rc, input int spur);
    for (int i = 0; i < NL; i++) begin
      if (bus.layer_start[i]) begin
        o_nstart[i]++;
        o_start_rc[i] = rc;
        due[i] = (lat[i] == 0) ? -1 : rc + lat[i];
      end
      if (bus.layer_ena[i]) o_enacnt[i]++;
    end
    if ($countones(bus.layer_ena) > 1) o_multi++;
    if (bus.done) begin
      o_ndone++;
      o_done_rc = rc;
    end
    for (int i = 0; i < NL; i++)
      bus.layer_done[i] = (due[i] == rc) ||
                          (!bus.layer_ena[i] && ((spur == 2) || (spur == 1 && $urandom_range(3) == 0)));
    @(posedge clk); #1;
  endtask

  task automatic do_run(input logic [NL-1:0] mask, input int spur, input int abort_rc, input int rr_to);
    int rc;
    for (int i = 0; i < NL; i++) begin
      o_nstart[i] = 0; o_start_rc[i] = -1; o_enacnt[i] = 0; due[i] = -1;
    end
    o_ndone = 0; o_done_rc = -1; o_multi = 0; o_end_rc = -1;
    rc = 0;
    while (o_end_rc < 0) begin
      bus.run_req    = (rc == 0) || (rc >= 2 && rc <= rr_to);
      bus.layer_mask = (rc == 0) ? mask : ~mask;   // must have been latched
      bus.abort      = (rc == abort_rc);
      step(rc, spur);
      rc++;
      if (rc > 1 && !bus.busy) o_end_rc = rc;
      if (rc > 600) begin
        n_cmp++; n_mis++;
        $error("FAIL run_bound observed=%0d expected=done_within_600", rc);
        o_end_rc = rc;
      end
    end
    bus.run_req = 1'b0; bus.abort = 1'b0; bus.layer_done = '0;
  endtask

  // Reference: walk the layers with cycle arithmetic. SELECT costs one cycle
  // per index; an executed layer starts the next cycle and needs lat cycles
  // to answer, or times out after TO waiting cycles.
  task automatic model(input logic [NL-1:0] mask);
    int t, s;
    t = 1; e_err = 0; e_errl = 0;
    for (int i = 0; i < NL; i++) begin
      e_start[i] = -1; e_ena[i] = 0;
      if (e_err == 0) begin
        if (!mask[i]) t++;
        else begin
          s = t + 1;
          e_start[i] = s;
          if (lat[i] >= 1 && lat[i] <= TO) begin
            e_ena[i] = lat[i] + 1;
            t = s + lat[i] + 1;
          end else begin
            e_ena[i] = TO + 1;
            e_err = 1; e_errl = i;
            e_runc = s + TO + 1;
          end
        end
      end
    end
    if (e_err == 0) begin
      e_ndone = 1; e_done_rc = t + 1; e_runc = t + 1;
    end else begin
      e_ndone = 0; e_done_rc = -1;
    end
    e_end = e_runc + 1;
  endtask

  task automatic run_and_check(input string tag, input logic [NL-1:0] mask, input int spur, input int rr_to);
    model(mask);
    do_run(mask, spur, -1, rr_to);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("%s_nstart%0d", tag, i), o_nstart[i], (e_start[i] >= 0) ? 1 : 0);
      check($sformatf("%s_start_rc%0d", tag, i), o_start_rc[i], e_start[i]);
      check($sformatf("%s_ena_len%0d", tag, i), o_enacnt[i], e_ena[i]);
    end
    check({tag, "_ndone"}, o_ndone, e_ndone);
    check({tag, "_done_rc"}, o_done_rc, e_done_rc);
    check({tag, "_multihot"}, o_multi, 0);
    check({tag, "_end_rc"}, o_end_rc, e_end);
    check({tag, "_error"}, bus.error, e_err);
    if (e_err != 0) check({tag, "_err_layer"}, bus.err_layer, e_errl);
    check({tag, "_run_cycles"}, bus.run_cycles, e_runc);
    check({tag, "_ena_idle"}, bus.layer_ena, 0);
  endtask

  initial begin
    logic [NL-1:0] m;
    rst = 1'b1;
    bus.run_req = 1'b0; bus.abort = 1'b0; bus.layer_mask = '0; bus.layer_done = '0;
    for (int i = 0; i < NL; i++) lat[i] = 10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_start", bus.layer_start, 0);
    check("rst_ena", bus.layer_ena, 0);
    check("rst_err_layer", bus.err_layer, 0);
    check("rst_cur_layer", bus.cur_layer, 0);
    check("rst_run_cycles", bus.run_cycles, 0);

    // all layers skipped: done at cycle 6, run_cycles 6
    run_and_check("skip_all", 4'b0000, 0, -1);
    check("skip_all_rc6", bus.run_cycles, 6);

    // all layers, 10-cycle engines
    run_and_check("all", 4'b1111, 0, -1);

    // sparse mask
    run_and_check("m0101", 4'b0101, 0, -1);

    // engine 1 never answers
    lat[1] = 0;
    run_and_check("timeout", 4'b1111, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("timeout_sticky", bus.error, 1);
    check("timeout_layer", bus.err_layer, 1);
    lat[1] = 10;
    run_and_check("after_err", 4'b0000, 0, -1);

    // abort three cycles into layer 0 WAIT; run_req during the run ignored
    do_run(4'b1111, 0, 5, 4);
    check("abort_end_rc", o_end_rc, 6);
    check("abort_ndone", o_ndone, 0);
    check("abort_ena", bus.layer_ena, 0);
    check("abort_start0", o_nstart[0], 1);
    check("abort_start1", o_nstart[1], 0);
    check("abort_error", bus.error, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", bus.busy, 0);
    run_and_check("post_abort", 4'b1111, 0, -1);

    // spurious done on idle layers; layer 1 answers exactly at the timeout
    lat[0] = 3; lat[1] = TO; lat[2] = 2; lat[3] = 5;
    run_and_check("coincide", 4'b1111, 2, -1);

    // mid-run reset behaves like power-on reset
    bus.layer_mask = 4'b1111; bus.run_req = 1'b1;
    @(posedge clk); #1;
    bus.run_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_ena", bus.layer_ena, 0);
    check("midrst_run_cycles", bus.run_cycles, 0);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      m = NL'($urandom);
      for (int i = 0; i < NL; i++) lat[i] = $urandom_range(18, 1);
      run_and_check($sformatf("rnd%0d", r), m, 1, $urandom_range(10, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
